issue_unit: RTL
===============

ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 Parameter DUAL_ISSUE, default 1; 0 SHALL force single issue (o_size never 2).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 flush  input  1  pipeline flush from commit; same clocking as reset.
REQ-005 i_a_valid, i_b_valid  input  1 each  instruction-buffer slot a/b occupied; b valid implies a valid.
REQ-006 i_a_pc, i_b_pc  input  32 each  slot PCs.
REQ-007 i_a_optype, i_b_optype  input  optype_t each  ALU/MUL/DIV/MEM/BR/PRIV class.
REQ-008 i_a_dest, i_b_dest  input  5 each  destination register; 0 = none.
REQ-009 i_a_r1, i_a_r2, i_b_r1, i_b_r2  input  5 each  source registers; 0 = none.
REQ-010 i_a_src2_is_imm, i_b_src2_is_imm  input  1 each  r2 unused when high.
REQ-011 i_a_have_excp, i_b_have_excp  input  1 each  slot carries exception/interrupt.
REQ-012 o_size  output  2  instructions consumed from the buffer this cycle (0/1/2).
REQ-013 ex_stall  input  1  execute stage cannot accept new instructions.
REQ-014 ex_a_valid, ex_b_valid  output  1 each  registered issue-slot valids.
REQ-015 ex_a_pc, ex_b_pc, ex_a_optype, ex_b_optype, ex_a_dest, ex_b_dest  output  as inputs  registered copies of issued slot fields.
REQ-016 wb_a_en, wb_b_en  input  1 each  long-latency writeback valid.
REQ-017 wb_a_dest, wb_b_dest  input  5 each  register written back.
REQ-018 sb_empty  output  1  no register busy in the scoreboard.

Function
REQ-019 o_size SHALL be combinational from current inputs and state; ex_* SHALL update on the next posedge (1-cycle latency).
REQ-020 ex_stall high SHALL force o_size=0 and hold all ex_* registers unchanged.
REQ-021 Scoreboard: 32 busy bits; bit 0 SHALL always read 0.
REQ-022 Issued MEM, MUL or DIV with dest!=0 SHALL set busy[dest] at the issue edge.
REQ-023 wb_x_en SHALL clear busy[wb_x_dest] at that edge; same-edge set and clear of one register SHALL leave it set.
REQ-024 Slot a issues iff i_a_valid, !ex_stall, busy[r1]=0 and (src2_is_imm or busy[r2]=0).
REQ-025 Slot a with optype PRIV or have_excp SHALL additionally require sb_empty and SHALL issue alone.
REQ-026 Slot b issues iff DUAL_ISSUE, slot a issues, i_b_valid, b sources not busy, and b is not PRIV and not have_excp.
REQ-027 Slot b SHALL NOT issue if a is BR, PRIV or have_excp, or if a.dest!=0 equals b.r1 or (non-imm) b.r2.
REQ-028 Slot b SHALL NOT issue if a and b are both MEM, or both in {MUL, DIV}.
REQ-029 o_size = 2 if b issues, else 1 if a issues, else 0; ex_a_valid/ex_b_valid SHALL load the per-slot issue decision when !ex_stall.
REQ-030 Issued slot fields SHALL be captured into ex_*; non-issued slots SHALL load valid=0.

Reset
REQ-031 reset or flush SHALL clear all busy bits and ex_a_valid/ex_b_valid; ex_* data fields need no reset.
REQ-032 During reset or flush, o_size SHALL be 0 and wb_* inputs SHALL be ignored.
REQ-033 After reset, sb_empty SHALL read 1.

Structure
REQ-034 optype_t and its enumerants SHALL live in the shared definitions package; the 2-bit issue-count encoding SHALL be a shared constant.
REQ-035 The scoreboard SHALL be a sub-module, issue_scoreboard (two set ports, two clear ports, two read ports per slot, empty flag).

Verification
REQ-036 a=ALU r1=1 dest=2, b=ALU r1=3 dest=4, empty scoreboard -> o_size=2; next cycle ex_a_valid=ex_b_valid=1.
REQ-037 a=ALU dest=5, b reads r5 -> o_size=1; next cycle b (now in slot a) issues.
REQ-038 Issue MEM dest=7, then ALU r1=7 -> o_size=0 until wb_a_en with dest 7; issue on that cycle's successor.
REQ-039 busy[9] set, PRIV in slot a -> o_size=0 until busy[9] clears, then o_size=1 with b held.
REQ-040 ex_stall=1 with two issuable slots -> o_size=0, ex_* held; deassert -> o_size=2.
REQ-041 flush while busy[3]=1 and ex valids=1 -> next cycle sb_empty=1, ex_a_valid=ex_b_valid=0.

Source files
------------

// File: rtl/issue_unit_pkg.sv
// Shared definitions for the issue unit: operation classes, issue-count
// encoding and small classification helpers.
package issue_unit_pkg;

  typedef enum logic [2:0] {
    OP_ALU  = 3'd0,
    OP_MUL  = 3'd1,
    OP_DIV  = 3'd2,
    OP_MEM  = 3'd3,
    OP_BR   = 3'd4,
    OP_PRIV = 3'd5
  } optype_t;

  localparam logic [1:0] ISSUE_NONE = 2'd0;
  localparam logic [1:0] ISSUE_ONE  = 2'd1;
  localparam logic [1:0] ISSUE_TWO  = 2'd2;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned NUM_REGS = 32;

  // Long-latency ops write back out of band and must reserve their dest.
  function automatic logic is_long_lat(input optype_t op);
    return (op == OP_MEM) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_muldiv(input optype_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/issue_unit_scoreboard.sv
// Register busy scoreboard: two reservation ports, two writeback clear
// ports, four source read ports and an all-clear flag.
module issue_scoreboard
  import issue_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              set_a_en,
  input  logic [REG_AW-1:0] set_a_dest,
  input  logic              set_b_en,
  input  logic [REG_AW-1:0] set_b_dest,
  input  logic              clr_a_en,
  input  logic [REG_AW-1:0] clr_a_dest,
  input  logic              clr_b_en,
  input  logic [REG_AW-1:0] clr_b_dest,
  input  logic [REG_AW-1:0] rd_a_r1,
  input  logic [REG_AW-1:0] rd_a_r2,
  input  logic [REG_AW-1:0] rd_b_r1,
  input  logic [REG_AW-1:0] rd_b_r2,
  output logic              busy_a_r1,
  output logic              busy_a_r2,
  output logic              busy_b_r1,
  output logic              busy_b_r2,
  output logic              empty
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clears are applied before sets so a same-edge set/clear leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (clr_a_en) busy_d[clr_a_dest] = 1'b0;
    if (clr_b_en) busy_d[clr_b_dest] = 1'b0;
    if (set_a_en) busy_d[set_a_dest] = 1'b1;
    if (set_b_en) busy_d[set_b_dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_a_r1 = busy_q[rd_a_r1];
  assign busy_a_r2 = busy_q[rd_a_r2];
  assign busy_b_r1 = busy_q[rd_b_r1];
  assign busy_b_r2 = busy_q[rd_b_r2];
  assign empty     = (busy_q == '0);

endmodule

// File: rtl/issue_unit.sv
// Dual-slot in-order issue stage: hazard checks against the scoreboard and
// pairing rules, then registers the issued slots toward execute.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int DUAL_ISSUE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              i_a_valid,
  input  logic              i_b_valid,
  input  logic [31:0]       i_a_pc,
  input  logic [31:0]       i_b_pc,
  input  optype_t           i_a_optype,
  input  optype_t           i_b_optype,
  input  logic [REG_AW-1:0] i_a_dest,
  input  logic [REG_AW-1:0] i_b_dest,
  input  logic [REG_AW-1:0] i_a_r1,
  input  logic [REG_AW-1:0] i_a_r2,
  input  logic [REG_AW-1:0] i_b_r1,
  input  logic [REG_AW-1:0] i_b_r2,
  input  logic              i_a_src2_is_imm,
  input  logic              i_b_src2_is_imm,
  input  logic              i_a_have_excp,
  input  logic              i_b_have_excp,
  output logic [1:0]        o_size,
  input  logic              ex_stall,
  output logic              ex_a_valid,
  output logic              ex_b_valid,
  output logic [31:0]       ex_a_pc,
  output logic [31:0]       ex_b_pc,
  output optype_t           ex_a_optype,
  output optype_t           ex_b_optype,
  output logic [REG_AW-1:0] ex_a_dest,
  output logic [REG_AW-1:0] ex_b_dest,
  input  logic              wb_a_en,
  input  logic              wb_b_en,
  input  logic [REG_AW-1:0] wb_a_dest,
  input  logic [REG_AW-1:0] wb_b_dest,
  output logic              sb_empty
);

  localparam logic DUAL_EN = (DUAL_ISSUE != 0);

  logic busy_a_r1, busy_a_r2, busy_b_r1, busy_b_r2;
  logic sb_empty_w;
  logic hold;
  logic a_special, b_special;
  logic a_src_ok, b_src_ok;
  logic raw_ab, pair_conflict;
  logic issue_a, issue_b;
  logic set_a_en, set_b_en;

  logic              ex_a_valid_q, ex_a_valid_d;
  logic              ex_b_valid_q, ex_b_valid_d;
  logic [31:0]       ex_a_pc_q, ex_a_pc_d;
  logic [31:0]       ex_b_pc_q, ex_b_pc_d;
  optype_t           ex_a_optype_q, ex_a_optype_d;
  optype_t           ex_b_optype_q, ex_b_optype_d;
  logic [REG_AW-1:0] ex_a_dest_q, ex_a_dest_d;
  logic [REG_AW-1:0] ex_b_dest_q, ex_b_dest_d;

  assign hold = reset || flush;

  always_comb begin
    a_special = (i_a_optype == OP_PRIV) || i_a_have_excp;
    b_special = (i_b_optype == OP_PRIV) || i_b_have_excp;
    a_src_ok  = !busy_a_r1 && (i_a_src2_is_imm || !busy_a_r2);
    b_src_ok  = !busy_b_r1 && (i_b_src2_is_imm || !busy_b_r2);

    raw_ab = (i_a_dest != '0) &&
             ((i_a_dest == i_b_r1) || (!i_b_src2_is_imm && (i_a_dest == i_b_r2)));

    // Only one memory port and one shared mul/div unit downstream.
    pair_conflict = ((i_a_optype == OP_MEM) && (i_b_optype == OP_MEM)) ||
                    (is_muldiv(i_a_optype) && is_muldiv(i_b_optype));

    issue_a = i_a_valid && !ex_stall && !hold && a_src_ok &&
              (!a_special || sb_empty_w);

    issue_b = DUAL_EN && issue_a && i_b_valid && b_src_ok && !b_special &&
              !a_special && (i_a_optype != OP_BR) && !raw_ab && !pair_conflict;

    if (issue_b)      o_size = ISSUE_TWO;
    else if (issue_a) o_size = ISSUE_ONE;
    else              o_size = ISSUE_NONE;

    set_a_en = issue_a && is_long_lat(i_a_optype) && (i_a_dest != '0);
    set_b_en = issue_b && is_long_lat(i_b_optype) && (i_b_dest != '0);
  end

  issue_scoreboard u_sb (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .set_a_en   (set_a_en),
    .set_a_dest (i_a_dest),
    .set_b_en   (set_b_en),
    .set_b_dest (i_b_dest),
    .clr_a_en   (wb_a_en && !hold),
    .clr_a_dest (wb_a_dest),
    .clr_b_en   (wb_b_en && !hold),
    .clr_b_dest (wb_b_dest),
    .rd_a_r1    (i_a_r1),
    .rd_a_r2    (i_a_r2),
    .rd_b_r1    (i_b_r1),
    .rd_b_r2    (i_b_r2),
    .busy_a_r1  (busy_a_r1),
    .busy_a_r2  (busy_a_r2),
    .busy_b_r1  (busy_b_r1),
    .busy_b_r2  (busy_b_r2),
    .empty      (sb_empty_w)
  );

  always_comb begin
    ex_a_valid_d  = ex_a_valid_q;
    ex_b_valid_d  = ex_b_valid_q;
    ex_a_pc_d     = ex_a_pc_q;
    ex_b_pc_d     = ex_b_pc_q;
    ex_a_optype_d = ex_a_optype_q;
    ex_b_optype_d = ex_b_optype_q;
    ex_a_dest_d   = ex_a_dest_q;
    ex_b_dest_d   = ex_b_dest_q;
    if (!ex_stall) begin
      ex_a_valid_d = issue_a;
      ex_b_valid_d = issue_b;
      if (issue_a) begin
        ex_a_pc_d     = i_a_pc;
        ex_a_optype_d = i_a_optype;
        ex_a_dest_d   = i_a_dest;
      end
      if (issue_b) begin
        ex_b_pc_d     = i_b_pc;
        ex_b_optype_d = i_b_optype;
        ex_b_dest_d   = i_b_dest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hold) begin
      ex_a_valid_q <= 1'b0;
      ex_b_valid_q <= 1'b0;
    end else begin
      ex_a_valid_q <= ex_a_valid_d;
      ex_b_valid_q <= ex_b_valid_d;
    end
  end

  // Payload fields are qualified by the valids and need no reset.
  always_ff @(posedge clk) begin
    ex_a_pc_q     <= ex_a_pc_d;
    ex_b_pc_q     <= ex_b_pc_d;
    ex_a_optype_q <= ex_a_optype_d;
    ex_b_optype_q <= ex_b_optype_d;
    ex_a_dest_q   <= ex_a_dest_d;
    ex_b_dest_q   <= ex_b_dest_d;
  end

  assign ex_a_valid  = ex_a_valid_q;
  assign ex_b_valid  = ex_b_valid_q;
  assign ex_a_pc     = ex_a_pc_q;
  assign ex_b_pc     = ex_b_pc_q;
  assign ex_a_optype = ex_a_optype_q;
  assign ex_b_optype = ex_b_optype_q;
  assign ex_a_dest   = ex_a_dest_q;
  assign ex_b_dest   = ex_b_dest_q;
  assign sb_empty    = sb_empty_w;

endmodule
